// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states, legal parameter ranges.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int unsigned MIN_CLOCKS_PER_PULSE = 2;
  localparam int unsigned MIN_DATA_BITS        = 5;
  localparam int unsigned MAX_DATA_BITS        = 9;
  localparam int unsigned MIN_STOP_BITS        = 1;
  localparam int unsigned MAX_STOP_BITS        = 2;

  // Mode 3 is reserved and deliberately folds onto NONE.
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return ODD;
      2'd2:    return EVEN;
      default: return NONE;
    endcase
  endfunction

  function automatic bit params_legal(input int unsigned cpp,
                                      input int unsigned data_bits,
                                      input int unsigned stop_bits);
    return (cpp >= MIN_CLOCKS_PER_PULSE) &&
           (data_bits >= MIN_DATA_BITS) && (data_bits <= MAX_DATA_BITS) &&
           (stop_bits >= MIN_STOP_BITS) && (stop_bits <= MAX_STOP_BITS);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side valid/ready word interface of the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] in_data;
  logic [1:0]           in_parity;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_parity, output in_valid, input in_ready);
  modport slave  (input in_data, input in_parity, input in_valid, output in_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLOCKS_PER_PULSE-1, strobes on the last clock, sync clear.
module uart_bit_timer #(
  parameter int unsigned CLOCKS_PER_PULSE = 16,
  parameter int unsigned CNT_W            = $clog2(CLOCKS_PER_PULSE)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic bit_end,
  output logic near_end
);

  logic [CNT_W-1:0] cnt;

  assign bit_end  = (cnt == CNT_W'(CLOCKS_PER_PULSE - 1));
  assign near_end = (cnt == CNT_W'(CLOCKS_PER_PULSE - 2));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, LSB-first payload, optional parity, 1-2 stop bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 16,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic           clk,
  input  logic           rstn,
  uart_tx_cfg_if.slave   in_if,
  output logic           tx,
  output logic           tx_busy,
  output logic           tx_done
);

  localparam int unsigned CNT_W = $clog2(STOP_BITS * CLOCKS_PER_PULSE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  if (!params_legal(CLOCKS_PER_PULSE, DATA_BITS, STOP_BITS)) begin : g_param_check
    $error("uart_tx_cfg: illegal CLOCKS_PER_PULSE/DATA_BITS/STOP_BITS");
  end

  tx_state_e            state;
  parity_e              par_mode;
  logic                 par_bit;
  logic [DATA_BITS-1:0] shreg;
  logic [BIT_W-1:0]     bit_idx;
  logic                 ready_q;
  logic                 bit_end;
  logic                 near_end;
  logic                 accept;
  logic                 last_data;
  logic                 last_stop;

  assign in_if.in_ready = ready_q;
  assign accept         = in_if.in_valid && ready_q;
  assign last_data      = (bit_idx == BIT_W'(DATA_BITS - 1));
  assign last_stop      = (bit_idx == BIT_W'(STOP_BITS - 1));

  uart_bit_timer #(
    .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
    .CNT_W            (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (state == IDLE),
    .bit_end  (bit_end),
    .near_end (near_end)
  );

  // tx is loaded one edge ahead of each bit, so every bit spans exactly one timer period.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      tx       <= 1'b1;
      ready_q  <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      par_mode <= NONE;
      bit_idx  <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (accept) begin
            shreg    <= in_if.in_data;
            par_mode <= decode_parity(in_if.in_parity);
            par_bit  <= (decode_parity(in_if.in_parity) == ODD) ? ~^in_if.in_data
                                                                 :  ^in_if.in_data;
            bit_idx  <= '0;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            ready_q  <= 1'b0;
            state    <= START;
          end else begin
            ready_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (last_data) begin
              bit_idx <= '0;
              if (par_mode != NONE) begin
                tx    <= par_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (near_end && last_stop) tx_done <= 1'b1;
          if (bit_end) begin
            if (last_stop) begin
              bit_idx <= '0;
              tx_busy <= 1'b0;
              ready_q <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
